tournament_predictor: RTL
=========================

Name: tournament_predictor

Overview:
- Parametrised direction predictor for the fetch stage. It supersedes the fixed 10-bit-history, single-PHT direction path.
- Combines a bimodal PHT and a gshare PHT under a per-PC chooser table.
- Keeps a speculative global history register (GHR) with one-cycle recovery on mispredict.
- Clears all tables with a post-reset init sweep, so the tables map to RAM-style storage.
- Sits beside the BTB/RAS in fetch; the BTB still supplies branch type and target.

Parameters:
- PC_W, 64, program counter width.
- GHR_W, 10, global history length; must be <= GSH_IDX_W.
- BIM_IDX_W, 8, bimodal PHT index width (2^BIM_IDX_W entries).
- GSH_IDX_W, 10, gshare PHT index width.
- CHO_IDX_W, 8, chooser table index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- pred_valid_i  in  1  fetch requests a prediction for pc_i this cycle
- pc_i  in  PC_W  fetch PC
- spec_push_i  in  1  fetch shifts a speculative direction into the GHR
- spec_taken_i  in  1  direction shifted when spec_push_i=1
- update_en_i  in  1  resolved conditional branch from execute
- pc_u_i  in  PC_W  PC of the resolved branch
- taken_u_i  in  1  resolved direction
- ghr_u_i  in  GHR_W  GHR snapshot carried with the branch (its pred_ghr_o)
- mispredict_u_i  in  1  resolved direction differed from the prediction
- ready_o  out  1  init sweep complete; predictions valid
- pred_taken_o  out  1  predicted direction
- pred_ghr_o  out  GHR_W  speculative GHR used for this prediction
- pred_provider_o  out  1  0 = bimodal chose, 1 = gshare chose

Behaviour:
- Reset: state=INIT, sweep index=0, GHR=0. Outputs during reset: ready_o=0, pred_taken_o=0, pred_ghr_o=0, pred_provider_o=0.
- FSM INIT:
  - Writes one entry per cycle at sweep index i, across all three tables where i is in range.
  - Values written: bimodal and gshare = 2'b01 (weak not-taken); chooser = 2'b01 (weak bimodal).
  - Sweep covers 0 .. 2^max(BIM,GSH,CHO)-1.
  - Transitions to RUN on the cycle after the last index is written; ready_o=1 from that cycle on.
  - Inputs are ignored during INIT; pred_taken_o is forced to 0.
- FSM RUN: stays in RUN until reset. Reset asserted mid-sweep or mid-run restarts INIT from index 0.
- Indexing:
  - bim_idx = pc[BIM_IDX_W+1:2]
  - gsh_idx = pc[GSH_IDX_W+1:2] XOR zero-extended GHR
  - cho_idx = pc[CHO_IDX_W+1:2]
  - The same functions apply at update time, using pc_u_i and ghr_u_i.
- Prediction:
  - Combinational, same cycle as pc_i.
  - pred_provider_o = cho[1]. pred_taken_o = MSB of the selected counter.
  - pred_ghr_o = current GHR, before any same-cycle shift.
  - Outputs are valid when ready_o & pred_valid_i. When pred_valid_i=0, pred_taken_o=0.
- Table update (RUN, update_en_i=1):
  - Bimodal and gshare counters: 2-bit saturating toward taken_u_i.
  - Chooser: updated only when the bimodal and gshare MSBs at the update indices differ. It moves toward gshare (+1) if gshare was correct, toward bimodal (-1) otherwise, saturating at 0 and 3.
  - Table writes land at the clock edge.
- Same-cycle read and write to the same entry: the prediction sees the old value; there is no bypass.
- GHR shift convention: new bit enters the LSB.
- GHR priority, highest first:
  1. update_en_i & mispredict_u_i: GHR <= {ghr_u_i[GHR_W-2:0], taken_u_i}.
  2. spec_push_i: GHR <= {GHR[GHR_W-2:0], spec_taken_i}.
  3. Otherwise hold.
- GHR_W == 1: on recovery, GHR <= taken_u_i.
- Update with mispredict_u_i=0 never touches the GHR.

Decomposition:
- Add to cpu_consts:
  - tp_state_t enum {TP_INIT, TP_RUN}.
  - Counter init constants CNT_WEAK_NT=2'b01 and CHO_WEAK_BIM=2'b01.
  - sat_cnt_next(cnt, up) function.
- Reuse bp_cnt_t from the shared package.
- One sub-module, tp_pht_bank (parameter IDX_W, INIT_VAL):
  - Counter array with one async read port, plus one write port muxed between init and update.
  - Instantiated three times: bimodal, gshare, chooser.
- The FSM, GHR and index logic stay in the top module.

Test Plan:
- Reset release, defaults → ready_o=0 for exactly 1024 cycles, then 1; during the sweep pred_taken_o=0 despite pred_valid_i=1.
- After init, pc_i=0x1000 → pred_taken_o=0, pred_provider_o=0. Then two updates on pc_u_i=0x1000 with taken_u_i=1 → bimodal counter reaches 2'b11 and pred_taken_o=1.
- Saturation: five taken updates on one PC → counter holds at 3. Five not-taken updates → holds at 0, with no wrap.
- Chooser: branch at 0x2040 alternates T/N with a repeating history. After 4 disagreeing updates where gshare is correct, pred_provider_o=1 for pc_i=0x2040.
- GHR: spec_push_i with taken bits 1,0,1 from GHR=0 → pred_ghr_o=0x005. Same cycle as a further push: mispredict with ghr_u_i=0x3FF, taken_u_i=0 → next GHR=0x3FE; the push is dropped.
- Reset asserted at sweep index 500 → ready_o drops, and after release the sweep restarts from index 0 (1024 cycles to ready_o).

Source files
------------

// File: rtl/tournament_predictor_pkg.sv
// Shared types and helpers for the tournament direction predictor.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package tournament_predictor_pkg;

  // 2-bit saturating branch counter shared by all predictor tables.
  typedef logic [1:0] bp_cnt_t;

  typedef enum logic {
    TP_INIT = 1'b0,
    TP_RUN  = 1'b1
  } tp_state_t;

  // Post-reset contents: direction tables weakly not-taken,
  // chooser weakly trusting the bimodal table.
  localparam bp_cnt_t CNT_WEAK_NT  = 2'b01;
  localparam bp_cnt_t CHO_WEAK_BIM = 2'b01;

  // One step of a 2-bit saturating counter: up=1 counts toward 3, up=0 toward 0.
  function automatic bp_cnt_t sat_cnt_next(input bp_cnt_t cnt, input logic up);
    if (up) begin
      return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    end
    return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

endpackage

// File: rtl/tournament_predictor_pht_bank.sv
// Counter table: one async prediction read, one write port shared by init sweep and update.
// Latency: reads combinational; writes land at the next clk edge.
// Backpressure: none; the init sweep has priority over updates on the write port.
// Ports: clk; init_en/init_idx (sweep write of INIT_VAL, ignored when init_idx is beyond
//        the table); rd_idx/rd_cnt (prediction read); upd_en/upd_idx/upd_up (saturating
//        read-modify-write); upd_cnt (current value at upd_idx, before the write).
module tp_pht_bank
  import tournament_predictor_pkg::*;
#(
  parameter int unsigned IDX_W    = 8,
  parameter int unsigned SWEEP_W  = 10,
  parameter bp_cnt_t     INIT_VAL = CNT_WEAK_NT
) (
  input  logic               clk,
  input  logic               init_en,
  input  logic [SWEEP_W-1:0] init_idx,
  input  logic [IDX_W-1:0]   rd_idx,
  output bp_cnt_t            rd_cnt,
  input  logic               upd_en,
  input  logic [IDX_W-1:0]   upd_idx,
  input  logic               upd_up,
  output bp_cnt_t            upd_cnt
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  // No reset on the array so it can map onto RAM; the init sweep clears it.
  bp_cnt_t mem [DEPTH];

  logic              init_hit;
  logic              we;
  logic [IDX_W-1:0]  waddr;
  bp_cnt_t           wdat;

  // The sweep spans the largest table, so smaller tables skip the upper indices.
  assign init_hit = init_en && (32'(init_idx) < DEPTH);

  always_comb begin
    we    = 1'b0;
    waddr = upd_idx;
    wdat  = sat_cnt_next(upd_cnt, upd_up);
    if (init_en) begin
      we    = init_hit;
      waddr = init_idx[IDX_W-1:0];
      wdat  = INIT_VAL;
    end else if (upd_en) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdat;
    end
  end

  // No write-to-read bypass: a same-cycle read sees the old value.
  assign rd_cnt  = mem[rd_idx];
  assign upd_cnt = mem[upd_idx];

endmodule

// File: rtl/tournament_predictor.sv
// Tournament direction predictor: bimodal + gshare PHTs picked by a per-PC chooser.
// Latency: prediction combinational with pc_i; table and GHR updates land at the next edge.
// Backpressure: none; ready_o stays low during the post-reset sweep, inputs ignored meanwhile.
// Ports: clk, reset (async, active high); pred_valid_i/pc_i -> pred_taken_o, pred_ghr_o,
//        pred_provider_o (0 bimodal, 1 gshare); spec_push_i/spec_taken_i shift the GHR;
//        update_en_i, pc_u_i, taken_u_i, ghr_u_i, mispredict_u_i train tables and recover GHR.
module tournament_predictor
  import tournament_predictor_pkg::*;
#(
  parameter int unsigned PC_W      = 64,
  parameter int unsigned GHR_W     = 10,
  parameter int unsigned BIM_IDX_W = 8,
  parameter int unsigned GSH_IDX_W = 10,
  parameter int unsigned CHO_IDX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_valid_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic             spec_push_i,
  input  logic             spec_taken_i,
  input  logic             update_en_i,
  input  logic [PC_W-1:0]  pc_u_i,
  input  logic             taken_u_i,
  input  logic [GHR_W-1:0] ghr_u_i,
  input  logic             mispredict_u_i,
  output logic             ready_o,
  output logic             pred_taken_o,
  output logic [GHR_W-1:0] pred_ghr_o,
  output logic             pred_provider_o
);

  localparam int unsigned BG_W    = (BIM_IDX_W > GSH_IDX_W) ? BIM_IDX_W : GSH_IDX_W;
  localparam int unsigned SWEEP_W = (BG_W > CHO_IDX_W) ? BG_W : CHO_IDX_W;
  localparam logic [SWEEP_W-1:0] SWEEP_LAST = '1;

  tp_state_t          state_q, state_d;
  logic [SWEEP_W-1:0] sweep_q;
  logic [GHR_W-1:0]   ghr_q, ghr_d, ghr_rec, ghr_spec;
  logic               run, init_en, upd_run;

  bp_cnt_t bim_rd, gsh_rd, cho_rd, bim_u, gsh_u, cho_u;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= TP_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == TP_INIT && sweep_q == SWEEP_LAST) state_d = TP_RUN;
  end

  always_comb begin
    run     = (state_q == TP_RUN);
    init_en = (state_q == TP_INIT);
    ready_o = run;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        sweep_q <= '0;
    else if (init_en) sweep_q <= sweep_q + SWEEP_W'(1);
  end

  // ---------------- GHR ----------------
  // New direction enters the LSB. Recovery rebuilds from the branch's snapshot.
  if (GHR_W == 1) begin : g_ghr_1
    assign ghr_rec  = taken_u_i;
    assign ghr_spec = spec_taken_i;
  end else begin : g_ghr_n
    assign ghr_rec  = {ghr_u_i[GHR_W-2:0], taken_u_i};
    assign ghr_spec = {ghr_q[GHR_W-2:0], spec_taken_i};
  end

  // Mispredict recovery beats a same-cycle speculative push.
  always_comb begin
    ghr_d = ghr_q;
    if (run) begin
      if (update_en_i && mispredict_u_i) ghr_d = ghr_rec;
      else if (spec_push_i)              ghr_d = ghr_spec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end

  // ---------------- Tables ----------------
  assign upd_run = run & update_en_i;

  tp_pht_bank #(.IDX_W(BIM_IDX_W), .SWEEP_W(SWEEP_W), .INIT_VAL(CNT_WEAK_NT)) u_bim (
    .clk      (clk),
    .init_en  (init_en),
    .init_idx (sweep_q),
    .rd_idx   (pc_i[BIM_IDX_W+1:2]),
    .rd_cnt   (bim_rd),
    .upd_en   (upd_run),
    .upd_idx  (pc_u_i[BIM_IDX_W+1:2]),
    .upd_up   (taken_u_i),
    .upd_cnt  (bim_u)
  );

  tp_pht_bank #(.IDX_W(GSH_IDX_W), .SWEEP_W(SWEEP_W), .INIT_VAL(CNT_WEAK_NT)) u_gsh (
    .clk      (clk),
    .init_en  (init_en),
    .init_idx (sweep_q),
    .rd_idx   (pc_i[GSH_IDX_W+1:2] ^ GSH_IDX_W'(ghr_q)),
    .rd_cnt   (gsh_rd),
    .upd_en   (upd_run),
    .upd_idx  (pc_u_i[GSH_IDX_W+1:2] ^ GSH_IDX_W'(ghr_u_i)),
    .upd_up   (taken_u_i),
    .upd_cnt  (gsh_u)
  );

  // Chooser trains only when the two predictors disagreed, toward whichever was right.
  tp_pht_bank #(.IDX_W(CHO_IDX_W), .SWEEP_W(SWEEP_W), .INIT_VAL(CHO_WEAK_BIM)) u_cho (
    .clk      (clk),
    .init_en  (init_en),
    .init_idx (sweep_q),
    .rd_idx   (pc_i[CHO_IDX_W+1:2]),
    .rd_cnt   (cho_rd),
    .upd_en   (upd_run & (bim_u[1] ^ gsh_u[1])),
    .upd_idx  (pc_u_i[CHO_IDX_W+1:2]),
    .upd_up   (gsh_u[1] == taken_u_i),
    .upd_cnt  (cho_u)
  );

  // ---------------- Prediction ----------------
  assign pred_provider_o = run & cho_rd[1];
  assign pred_taken_o    = run & pred_valid_i & (cho_rd[1] ? gsh_rd[1] : bim_rd[1]);
  assign pred_ghr_o      = ghr_q;

  // Only counter MSBs and the indexing PC bits matter; the rest are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{pc_i[PC_W-1:SWEEP_W+2], pc_i[1:0], pc_u_i[PC_W-1:SWEEP_W+2],
                         pc_u_i[1:0], bim_rd[0], gsh_rd[0], cho_rd[0], bim_u[0], gsh_u[0],
                         cho_u};

endmodule
